// File: rtl/tl_ul_initiator_if.sv
// TileLink-UL A/D channel pair between an initiator (master) and the crossbar (slave).
interface tl_ul_initiator_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SRC_W  = 2
);
   logic                  a_valid;
   logic                  a_ready;
   logic [2:0]            a_opcode;
   logic [2:0]            a_param;
   logic [2:0]            a_size;
   logic [SRC_W-1:0]      a_source;
   logic [ADDR_W-1:0]     a_address;
   logic [DATA_W-1:0]     a_data;
   logic [DATA_W/8-1:0]   a_mask;

   logic                  d_valid;
   logic                  d_ready;
   logic [2:0]            d_opcode;
   logic [SRC_W-1:0]      d_source;
   logic [DATA_W-1:0]     d_data;
   logic                  d_denied;
   logic                  d_corrupt;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_data, a_mask,
      input  a_ready,
      input  d_valid, d_opcode, d_source, d_data, d_denied, d_corrupt,
      output d_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_data, a_mask,
      output a_ready,
      output d_valid, d_opcode, d_source, d_data, d_denied, d_corrupt,
      input  d_ready
   );
endinterface

// File: rtl/tl_ul_initiator.sv
// TL-UL initiator: issues client commands on A with a pooled source ID, retires D
// responses to the client and flags opcode/source protocol violations (sticky).
module tl_ul_initiator #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SRC_W  = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_opcode,
   input  logic [2:0]          cmd_param,
   input  logic [2:0]          cmd_size,
   input  logic [ADDR_W-1:0]   cmd_address,
   input  logic [DATA_W-1:0]   cmd_data,
   input  logic [DATA_W/8-1:0] cmd_mask,
   tl_ul_initiator_if.master   tl,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic [SRC_W-1:0]    rsp_source,
   output logic                rsp_error,
   output logic [SRC_W:0]      outstanding,
   output logic                proto_err
);
   localparam int NSRC   = 1 << SRC_W;
   localparam int MASK_W = DATA_W / 8;

   localparam logic [2:0] D_ACK      = 3'd0;
   localparam logic [2:0] D_ACK_DATA = 3'd1;
   localparam logic [2:0] D_HINT_ACK = 3'd2;

   function automatic logic [2:0] expected_d_op(input logic [2:0] op);
      case (op)
         3'd0, 3'd1:       return D_ACK;
         3'd2, 3'd3, 3'd4: return D_ACK_DATA;
         default:          return D_HINT_ACK;
      endcase
   endfunction

   logic                   ready_en;
   logic                   a_valid_q;
   logic [2:0]             a_opcode_q, a_param_q, a_size_q;
   logic [SRC_W-1:0]       a_source_q;
   logic [ADDR_W-1:0]      a_address_q;
   logic [DATA_W-1:0]      a_data_q;
   logic [MASK_W-1:0]      a_mask_q;
   logic [NSRC-1:0]        busy_q, busy_nxt;
   logic [NSRC-1:0][2:0]   exp_q;
   logic [SRC_W:0]         outstanding_q;
   logic                   rsp_valid_q, rsp_error_q, proto_err_q;
   logic [DATA_W-1:0]      rsp_data_q;
   logic [SRC_W-1:0]       rsp_source_q;

   logic                   cmd_legal, cmd_fire, alloc;
   logic [SRC_W-1:0]       alloc_id;
   logic                   d_ready_w, d_fire, d_hit, d_op_bad, retire;

   assign cmd_legal = (cmd_opcode <= 3'd5);
   assign cmd_ready = ready_en && (!a_valid_q || tl.a_ready) && !(&busy_q);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign alloc     = cmd_fire && cmd_legal;

   assign d_ready_w = !rsp_valid_q || rsp_ready;
   assign d_fire    = tl.d_valid && d_ready_w;
   assign d_hit     = busy_q[tl.d_source];
   assign d_op_bad  = (exp_q[tl.d_source] != tl.d_opcode);
   assign retire    = d_fire && d_hit;

   // Allocation looks only at the registered bitmap, so an ID freed this cycle waits a cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      alloc_id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (!busy_q[i]) alloc_id = SRC_W'(i);
      end
   end

   always_comb begin
      busy_nxt = busy_q;
      if (retire) busy_nxt[tl.d_source] = 1'b0;
      if (alloc)  busy_nxt[alloc_id]    = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_en    <= 1'b0;
         a_valid_q   <= 1'b0;
         a_opcode_q  <= '0;
         a_param_q   <= '0;
         a_size_q    <= '0;
         a_source_q  <= '0;
         a_address_q <= '0;
         a_data_q    <= '0;
         a_mask_q    <= '0;
      end else begin
         ready_en <= 1'b1;
         if (alloc) begin
            a_valid_q   <= 1'b1;
            a_opcode_q  <= cmd_opcode;
            a_param_q   <= cmd_param;
            a_size_q    <= cmd_size;
            a_source_q  <= alloc_id;
            a_address_q <= cmd_address;
            a_data_q    <= cmd_data;
            a_mask_q    <= cmd_mask;
         end else if (tl.a_ready) begin
            a_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q        <= '0;
         // NOTE: the expected-opcode table is a handful of flops, so it is reset like any other state.
         exp_q         <= '0;
         outstanding_q <= '0;
      end else begin
         busy_q <= busy_nxt;
         if (alloc) exp_q[alloc_id] <= expected_d_op(cmd_opcode);
         case ({alloc, retire})
            2'b10:   outstanding_q <= outstanding_q + (SRC_W+1)'(1);
            2'b01:   outstanding_q <= outstanding_q - (SRC_W+1)'(1);
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_source_q <= '0;
         rsp_error_q  <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         if (retire) begin
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= tl.d_data;
            rsp_source_q <= tl.d_source;
            rsp_error_q  <= tl.d_denied | tl.d_corrupt;
         end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
         if ((cmd_fire && !cmd_legal) || (d_fire && (!d_hit || d_op_bad)))
            proto_err_q <= 1'b1;
      end
   end

   assign tl.a_valid   = a_valid_q;
   assign tl.a_opcode  = a_opcode_q;
   assign tl.a_param   = a_param_q;
   assign tl.a_size    = a_size_q;
   assign tl.a_source  = a_source_q;
   assign tl.a_address = a_address_q;
   assign tl.a_data    = a_data_q;
   assign tl.a_mask    = a_mask_q;
   assign tl.d_ready   = d_ready_w;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_source  = rsp_source_q;
   assign rsp_error   = rsp_error_q;
   assign outstanding = outstanding_q;
   assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_tl_ul_initiator.sv
// Self-checking bench for tl_ul_initiator: directed scenarios plus random traffic
// against a transaction-level model (in-flight map, A/rsp queues, sticky error bit).
module tb_tl_ul_initiator;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SRC_W  = 2;
   localparam int NSRC   = 1 << SRC_W;

   logic                  clock = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  cmd_valid, cmd_ready;
   logic [2:0]            cmd_opcode, cmd_param, cmd_size;
   logic [ADDR_W-1:0]     cmd_address;
   logic [DATA_W-1:0]     cmd_data;
   logic [DATA_W/8-1:0]   cmd_mask;
   logic                  rsp_valid, rsp_ready, rsp_error;
   logic [DATA_W-1:0]     rsp_data;
   logic [SRC_W-1:0]      rsp_source;
   logic [SRC_W:0]        outstanding;
   logic                  proto_err;

   always #5 clock = ~clock;

   tl_ul_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) tl ();

   tl_ul_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_param(cmd_param), .cmd_size(cmd_size), .cmd_address(cmd_address),
      .cmd_data(cmd_data), .cmd_mask(cmd_mask), .tl(tl),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_source(rsp_source), .rsp_error(rsp_error),
      .outstanding(outstanding), .proto_err(proto_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [2:0]          op, param, size;
      logic [SRC_W-1:0]    src;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   data;
      logic [DATA_W/8-1:0] mask;
   } a_beat_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [SRC_W-1:0]  src;
      logic              err;
   } rsp_t;

   a_beat_t    a_q[$];
   rsp_t       rsp_q[$];
   logic [2:0] inflight[int];
   bit         m_perr, m_up;

   function automatic logic [2:0] d_op_for(input logic [2:0] op);
      case (op)
         3'd0, 3'd1:       return 3'd0;
         3'd2, 3'd3, 3'd4: return 3'd1;
         default:          return 3'd2;
      endcase
   endfunction

   task automatic model_reset();
      a_q.delete();
      rsp_q.delete();
      inflight.delete();
      m_perr = 1'b0;
      m_up   = 1'b0;
   endtask

   // One clock: compare outputs with the model, advance the model, move to the next negedge.
   task automatic step(output bit cf, output bit df);
      bit         exp_cr, exp_dr, found;
      int         id, k;
      logic [2:0] snap[int];
      a_beat_t    b;
      #1;
      exp_cr = m_up && (a_q.size() == 0 || tl.a_ready) && (inflight.num() < NSRC);
      exp_dr = (rsp_q.size() == 0) || rsp_ready;
      check("cmd_ready", 64'(cmd_ready), 64'(exp_cr));
      check("d_ready", 64'(tl.d_ready), 64'(exp_dr));
      check("a_valid", 64'(tl.a_valid), 64'(a_q.size() != 0));
      if (a_q.size() != 0) begin
         check("a_ctl", 64'({tl.a_opcode, tl.a_param, tl.a_size, tl.a_source, tl.a_mask}),
               64'({a_q[0].op, a_q[0].param, a_q[0].size, a_q[0].src, a_q[0].mask}));
         check("a_address", 64'(tl.a_address), 64'(a_q[0].addr));
         check("a_data", 64'(tl.a_data), 64'(a_q[0].data));
      end
      check("rsp_valid", 64'(rsp_valid), 64'(rsp_q.size() != 0));
      if (rsp_q.size() != 0) begin
         check("rsp_data", 64'(rsp_data), 64'(rsp_q[0].data));
         check("rsp_src_err", 64'({rsp_source, rsp_error}), 64'({rsp_q[0].src, rsp_q[0].err}));
      end
      check("outstanding", 64'(outstanding), 64'(inflight.num()));
      check("proto_err", 64'(proto_err), 64'(m_perr));

      cf = cmd_valid && exp_cr;
      df = tl.d_valid && exp_dr;
      snap = inflight;
      if (a_q.size() != 0 && tl.a_ready) void'(a_q.pop_front());
      if (cf) begin
         if (cmd_opcode > 3'd5) m_perr = 1'b1;
         else begin
            found = 1'b0;
            id = 0;
            for (int i = 0; i < NSRC; i++) begin
               if (!found && !snap.exists(i)) begin
                  id = i;
                  found = 1'b1;
               end
            end
            b.op = cmd_opcode; b.param = cmd_param; b.size = cmd_size;
            b.src = SRC_W'(id); b.addr = cmd_address; b.data = cmd_data; b.mask = cmd_mask;
            a_q.push_back(b);
            inflight[id] = d_op_for(cmd_opcode);
         end
      end
      if (rsp_q.size() != 0 && rsp_ready) void'(rsp_q.pop_front());
      if (df) begin
         k = int'(tl.d_source);
         if (snap.exists(k)) begin
            if (tl.d_opcode != snap[k]) m_perr = 1'b1;
            inflight.delete(k);
            rsp_q.push_back('{tl.d_data, tl.d_source, tl.d_denied | tl.d_corrupt});
         end else begin
            m_perr = 1'b1;
         end
      end
      @(posedge clock);
      m_up = 1'b1;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      bit cf, df;
      for (int i = 0; i < n; i++) step(cf, df);
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [3:0] mask);
      bit cf, df;
      cmd_valid = 1'b1; cmd_opcode = op; cmd_address = addr; cmd_data = data;
      cmd_mask = mask; cmd_param = 3'(op); cmd_size = 3'd2;
      cf = 1'b0;
      for (int i = 0; i < 20 && !cf; i++) step(cf, df);
      if (!cf) check("cmd_timeout", 64'(cf), 64'(1));
      cmd_valid = 1'b0;
   endtask

   task automatic do_d(input logic [2:0] op, input logic [SRC_W-1:0] src,
                       input logic [DATA_W-1:0] data, input logic den, input logic cor);
      bit cf, df;
      tl.d_valid = 1'b1; tl.d_opcode = op; tl.d_source = src; tl.d_data = data;
      tl.d_denied = den; tl.d_corrupt = cor;
      df = 1'b0;
      for (int i = 0; i < 20 && !df; i++) step(cf, df);
      if (!df) check("d_timeout", 64'(df), 64'(1));
      tl.d_valid = 1'b0;
   endtask

   // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
   task automatic reset_dut();
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_a_valid", 64'(tl.a_valid), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      check("rst_outstanding", 64'(outstanding), 64'(0));
      check("rst_proto_err", 64'(proto_err), 64'(0));
      check("rst_a_address", 64'(tl.a_address), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit cf, df;
      int cands[$];
      int pick;
      cmd_valid = 1'b0; cmd_opcode = '0; cmd_param = '0; cmd_size = '0;
      cmd_address = '0; cmd_data = '0; cmd_mask = '0;
      tl.a_ready = 1'b1; tl.d_valid = 1'b0; tl.d_opcode = '0; tl.d_source = '0;
      tl.d_data = '0; tl.d_denied = 1'b0; tl.d_corrupt = 1'b0;
      rsp_ready = 1'b1;
      model_reset();

      repeat (3) @(negedge clock);
      check("por_a_valid", 64'(tl.a_valid), 64'(0));
      check("por_rsp_valid", 64'(rsp_valid), 64'(0));
      check("por_cmd_ready", 64'(cmd_ready), 64'(0));
      check("por_outstanding", 64'(outstanding), 64'(0));
      check("por_proto_err", 64'(proto_err), 64'(0));
      reset_n = 1'b1;

      // Single Get round trip
      do_cmd(3'd4, 32'h1000, 32'h0, 4'hf);
      check("get_opcode", 64'(tl.a_opcode), 64'(4));
      check("get_source", 64'(tl.a_source), 64'(0));
      idle(1);
      do_d(3'd1, 2'd0, 32'hDEADBEEF, 1'b0, 1'b0);
      check("get_rsp_data", 64'(rsp_data), 64'h0000_0000_DEAD_BEEF);
      check("get_rsp_src_err", 64'({rsp_source, rsp_error}), 64'(0));
      idle(2);
      check("get_outstanding", 64'(outstanding), 64'(0));
      check("get_proto_err", 64'(proto_err), 64'(0));

      // Fill the pool, then reuse the freed ID one cycle later
      for (int i = 0; i < NSRC; i++) begin
         do_cmd(3'd0, 32'h2000 + 32'(4 * i), 32'(i), 4'hf);
         check("put_source", 64'(tl.a_source), 64'(i));
      end
      idle(2);
      cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_address = 32'h2100;
      #1;
      check("full_cmd_ready", 64'(cmd_ready), 64'(0));
      check("full_outstanding", 64'(outstanding), 64'(4));
      tl.d_valid = 1'b1; tl.d_opcode = 3'd0; tl.d_source = 2'd2; tl.d_data = 32'h0;
      step(cf, df);
      tl.d_valid = 1'b0;
      do_cmd(3'd0, 32'h2100, 32'h77, 4'h3);
      check("reuse_source", 64'(tl.a_source), 64'(2));
      idle(1);
      do_d(3'd0, 2'd0, 32'h0, 1'b0, 1'b0);
      do_d(3'd0, 2'd1, 32'h0, 1'b1, 1'b0);
      do_d(3'd0, 2'd3, 32'h0, 1'b0, 1'b1);
      do_d(3'd0, 2'd2, 32'h0, 1'b0, 1'b0);
      idle(2);
      check("drain_outstanding", 64'(outstanding), 64'(0));

      // Hint answered with AccessAckData
      do_cmd(3'd5, 32'h4000, 32'h0, 4'hf);
      idle(1);
      do_d(3'd1, 2'd0, 32'h1234, 1'b0, 1'b0);
      check("hint_proto_err", 64'(proto_err), 64'(1));
      check("hint_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hint_freed", 64'(outstanding), 64'(0));
      idle(3);
      check("proto_err_sticky", 64'(proto_err), 64'(1));
      reset_dut();

      // Stray response while idle
      idle(1);
      do_d(3'd0, 2'd3, 32'h5555, 1'b0, 1'b0);
      check("stray_proto_err", 64'(proto_err), 64'(1));
      check("stray_no_rsp", 64'(rsp_valid), 64'(0));
      reset_dut();

      // A-side and D-side backpressure
      idle(1);
      tl.a_ready = 1'b0;
      do_cmd(3'd4, 32'h3000, 32'h0, 4'hf);
      cmd_valid = 1'b1; cmd_opcode = 3'd4; cmd_address = 32'h3004;
      for (int i = 0; i < 5; i++) begin
         step(cf, df);
         check("bp_a_hold", 64'(tl.a_address), 64'h3000);
         check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      end
      tl.a_ready = 1'b1;
      do_cmd(3'd4, 32'h3004, 32'h0, 4'hf);
      idle(2);
      rsp_ready = 1'b0;
      do_d(3'd1, 2'd0, 32'hA5A5A5A5, 1'b0, 1'b0);
      tl.d_valid = 1'b1; tl.d_opcode = 3'd1; tl.d_source = 2'd1; tl.d_data = 32'h5A5A5A5A;
      for (int i = 0; i < 3; i++) step(cf, df);
      check("bp_d_ready", 64'(tl.d_ready), 64'(0));
      check("bp_rsp_hold", 64'(rsp_data), 64'hA5A5A5A5);
      rsp_ready = 1'b1;
      do_d(3'd1, 2'd1, 32'h5A5A5A5A, 1'b0, 1'b0);
      check("bp_second_rsp", 64'(rsp_data), 64'h5A5A5A5A);
      idle(2);

      // Async reset with transactions in flight, then a late beat for a forgotten ID
      do_cmd(3'd4, 32'h5000, 32'h0, 4'hf);
      do_cmd(3'd2, 32'h5004, 32'h9, 4'hf);
      idle(1);
      check("pre_rst_outstanding", 64'(outstanding), 64'(2));
      reset_dut();
      do_d(3'd1, 2'd0, 32'h0, 1'b0, 1'b0);
      check("forgotten_proto_err", 64'(proto_err), 64'(1));
      reset_dut();

      // Random traffic
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (cyc == 400) reset_dut();
         cmd_valid   = 1'($urandom_range(0, 1));
         cmd_opcode  = ($urandom_range(0, 63) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         cmd_param   = 3'($urandom);
         cmd_size    = 3'($urandom);
         cmd_address = $urandom;
         cmd_data    = $urandom;
         cmd_mask    = 4'($urandom);
         tl.a_ready  = ($urandom_range(0, 3) != 0);
         rsp_ready   = ($urandom_range(0, 3) != 0);
         cands.delete();
         foreach (inflight[k]) begin
            if (!(a_q.size() != 0 && int'(a_q[0].src) == k)) cands.push_back(k);
         end
         tl.d_data    = $urandom;
         tl.d_denied  = ($urandom_range(0, 7) == 0);
         tl.d_corrupt = ($urandom_range(0, 7) == 0);
         tl.d_valid   = 1'b0;
         if ($urandom_range(0, 127) == 0) begin
            tl.d_valid  = 1'b1;
            tl.d_source = 2'($urandom);
            tl.d_opcode = 3'($urandom_range(0, 2));
         end else if (cands.size() != 0 && $urandom_range(0, 1) == 1) begin
            pick = cands[$urandom_range(0, cands.size() - 1)];
            tl.d_valid  = 1'b1;
            tl.d_source = 2'(pick);
            tl.d_opcode = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(0, 2)) : inflight[pick];
         end
         step(cf, df);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/tl_ul_initiator.md
# tl_ul_initiator

Request-issuing end of the TileLink-UL A/D channel pair. Accepts simple access commands from a local client and drives them onto the A channel with a unique source ID. It tracks up to 2^SRC_W outstanding transactions and retires D-channel responses back to the client. Each D response is checked against the response opcode the A opcode requires; violations raise a sticky protocol-error flag. Sits between a core-side client (debug/DMA-style requester) and the TL-UL crossbar, opposite the responder-side opcode translator.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (mask width DATA_W/8)
- SRC_W, 2, source-ID width; maximum outstanding = 2^SRC_W
- clock  input  1  sole clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  input / output  1 / 1  command handshake
- cmd_opcode  input  3  A opcode: 0 PutFull, 1 PutPartial, 2 Arithmetic, 3 Logical, 4 Get, 5 Hint
- cmd_param  input  3  A param, passed through
- cmd_size  input  3  log2 bytes, passed through
- cmd_address / cmd_data / cmd_mask  input  ADDR_W / DATA_W / DATA_W/8  payload
- a_valid / a_ready  output / input  1 / 1  A channel handshake
- a_opcode, a_param, a_size, a_source, a_address, a_data, a_mask  output  3,3,3,SRC_W,ADDR_W,DATA_W,DATA_W/8  A payload
- d_valid / d_ready  input / output  1 / 1  D channel handshake
- d_opcode, d_source, d_data, d_denied, d_corrupt  input  3,SRC_W,DATA_W,1,1  D payload
- rsp_valid / rsp_ready  output / input  1 / 1  response to client
- rsp_data, rsp_source, rsp_error  output  DATA_W, SRC_W, 1  rsp_error = d_denied | d_corrupt
- outstanding  output  SRC_W+1  count of in-flight transactions
- proto_err  output  1  sticky, cleared only by reset

## Operation
- Source pool: a bitmap of busy IDs plus a per-ID stored expected D opcode (3 bits).
- Expected D opcode: Put* → 0 AccessAck; Arithmetic, Logical, Get → 1 AccessAckData; Hint → 2 HintAck. Opcodes 6/7 are illegal on cmd.
  - On an illegal cmd opcode: accept the command, set proto_err, issue nothing, allocate nothing.
- A-side stage: a one-entry A register.
  - cmd_ready = (A register empty, or a_ready this cycle) AND at least one free ID.
  - On cmd fire: load the A register, allocate the lowest-indexed free ID, mark it busy, and store its expected opcode.
- A stability: while a_valid && !a_ready, all a_* outputs are held stable.
- D-side stage: a one-entry response register.
  - d_ready = !rsp_valid || rsp_ready.
  - On d fire with d_source busy: compare d_opcode with the stored expected opcode, set proto_err on mismatch, clear the busy bit, and load rsp_data/rsp_source/rsp_error.
  - On d fire with d_source not busy: set proto_err and drop the beat (no rsp).
- Simultaneous alloc and free in one cycle:
  - Both apply.
  - A freed ID is not allocatable until the next cycle; the free-vector used for allocation is the registered bitmap.
  - outstanding changes by +1, -1, or 0 accordingly.
- Pool full (outstanding = 2^SRC_W): cmd_ready = 0 until a response retires.

## Timing
- Reset values: a_valid 0, rsp_valid 0, cmd_ready 0 during reset. All payload registers are 0, busy bitmap 0, outstanding 0, proto_err 0.
- cmd_ready first goes high the first cycle after reset_n deasserts.
- cmd fire in cycle N → a_valid high in N+1. Back-to-back commands sustain 1 per cycle when a_ready = 1.
- d fire in cycle N → rsp_valid in N+1. Back-to-back responses sustain 1 per cycle when rsp_ready = 1.
- Response freeing ID k in cycle N → ID k allocatable from N+1. The outstanding count updates in N+1.
- proto_err asserts the cycle after the offending d fire or cmd fire.
- Reset asserted mid-transaction: all state clears immediately (async). In-flight IDs are forgotten.
  - A later D beat for a forgotten ID sets proto_err.
- No combinational path from cmd_* to a_*, or from d_* to rsp_*.
- The only combinational outputs are cmd_ready (from a_ready) and d_ready (from rsp_ready).

## Test plan
- Single Get (addr 0x1000) → a_opcode 4, a_source 0 at N+1. Reply d_opcode 1, data 0xDEADBEEF → rsp_data 0xDEADBEEF, rsp_source 0, rsp_error 0, proto_err 0, outstanding returns to 0.
- Issue 4 PutFull with a_ready = 1 and no D → sources 0,1,2,3 are issued, then cmd_ready = 0 and outstanding = 4. Respond source 2 with opcode 0 → next cmd gets source 2.
- Opcode check: Hint on source 0 answered with d_opcode 1 → proto_err = 1 and stays 1. rsp is still delivered, and source 0 is freed.
- Stray response: d_source 3 while idle → proto_err = 1, no rsp_valid.
- Backpressure: hold a_ready = 0 for 5 cycles → a_* stable and cmd_ready = 0. Hold rsp_ready = 0 → d_ready = 0 after the first response, with no data loss.
- Async reset asserted with 2 outstanding → all outputs return to their reset values within the same cycle. outstanding = 0 after reset_n deasserts.
